id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage_pkg.sv | 29 ++
 rtl/id_ex_stage_if.sv | 54 +++++
 rtl/id_ex_stage_operand_resolve.sv | 49 ++++
 rtl/id_ex_stage.sv | 144 ++++++++++++++
 tb/tb_id_ex_stage.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared types for the ID/EX operand stage
//
// Purpose: ALU operation codes and the stage state enum, shared by the
//          stage, its interface and the testbench.
// Contents: alu_sel_t, ALU_* codes, stage_state_e.
package id_ex_stage_pkg;

   typedef logic [3:0] alu_sel_t;

   localparam alu_sel_t ALU_NOP     = 4'h0;
   localparam alu_sel_t ALU_ADD     = 4'h1;
   localparam alu_sel_t ALU_SUB     = 4'h2;
   localparam alu_sel_t ALU_AND     = 4'h3;
   localparam alu_sel_t ALU_OR      = 4'h4;
   localparam alu_sel_t ALU_XOR     = 4'h5;
   localparam alu_sel_t ALU_SLL     = 4'h6;
   localparam alu_sel_t ALU_SRL     = 4'h7;
   localparam alu_sel_t ALU_SRA     = 4'h8;
   localparam alu_sel_t ALU_SLT     = 4'h9;
   localparam alu_sel_t ALU_SLTU    = 4'hA;
   localparam alu_sel_t ALU_INVALID = 4'hF;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_WAIT  = 2'd1,
      ST_FULL  = 2'd2
   } stage_state_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decode/forwarding/ALU bundle of the ID/EX stage
//
// Purpose: groups the decode offer, forwarding sources and ALU-side result.
// Modports: master - decode/pipeline side driving the stage;
//           slave  - the id_ex_stage itself.
interface id_ex_stage_if
   import id_ex_stage_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int REGW = 5
) ();

   logic            in_valid;
   logic            in_ready;
   alu_sel_t        in_alu_sel;
   logic [REGW-1:0] in_rs1;
   logic [REGW-1:0] in_rs2;
   logic [XLEN-1:0] in_rs1_data;
   logic [XLEN-1:0] in_rs2_data;
   logic [XLEN-1:0] in_imm;
   logic            in_use_imm;
   logic [REGW-1:0] in_rd;
   logic            flush;
   logic            ex_fwd_valid;
   logic            ex_fwd_is_load;
   logic [REGW-1:0] ex_fwd_rd;
   logic [XLEN-1:0] ex_fwd_data;
   logic            wb_fwd_valid;
   logic [REGW-1:0] wb_fwd_rd;
   logic [XLEN-1:0] wb_fwd_data;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] alu_a;
   logic [XLEN-1:0] alu_b;
   alu_sel_t        alu_sel;
   logic [REGW-1:0] out_rd;

   modport master (
      output in_valid, in_alu_sel, in_rs1, in_rs2, in_rs1_data, in_rs2_data,
             in_imm, in_use_imm, in_rd, flush,
             ex_fwd_valid, ex_fwd_is_load, ex_fwd_rd, ex_fwd_data,
             wb_fwd_valid, wb_fwd_rd, wb_fwd_data, out_ready,
      input  in_ready, out_valid, alu_a, alu_b, alu_sel, out_rd
   );

   modport slave (
      input  in_valid, in_alu_sel, in_rs1, in_rs2, in_rs1_data, in_rs2_data,
             in_imm, in_use_imm, in_rd, flush,
             ex_fwd_valid, ex_fwd_is_load, ex_fwd_rd, ex_fwd_data,
             wb_fwd_valid, wb_fwd_rd, wb_fwd_data, out_ready,
      output in_ready, out_valid, alu_a, alu_b, alu_sel, out_rd
   );

endinterface

// File: rtl/id_ex_stage_operand_resolve.sv
// rtl/id_ex_stage_operand_resolve.sv - forwarding priority for one source operand
//
// Purpose: picks the value for one source register: x0, EX/MEM forward,
//          writeback forward or register-file data; flags a pending load.
// Ports: rs_i/rf_data_i - source index and fallback data;
//        ex_fwd_*_i / wb_fwd_*_i - forwarding producers;
//        pending_o - EX producer is a load whose data is not ready;
//        value_o - resolved value (rf_data_i while pending).
module operand_resolve
   import id_ex_stage_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int REGW = 5
) (
   input  logic [REGW-1:0] rs_i,
   input  logic [XLEN-1:0] rf_data_i,
   input  logic            ex_fwd_valid_i,
   input  logic            ex_fwd_is_load_i,
   input  logic [REGW-1:0] ex_fwd_rd_i,
   input  logic [XLEN-1:0] ex_fwd_data_i,
   input  logic            wb_fwd_valid_i,
   input  logic [REGW-1:0] wb_fwd_rd_i,
   input  logic [XLEN-1:0] wb_fwd_data_i,
   output logic            pending_o,
   output logic [XLEN-1:0] value_o
);

   logic ex_hit;
   logic wb_hit;

   assign ex_hit = ex_fwd_valid_i && (ex_fwd_rd_i == rs_i);
   assign wb_hit = wb_fwd_valid_i && (wb_fwd_rd_i == rs_i);

   always_comb begin
      pending_o = 1'b0;
      value_o   = rf_data_i;
      if (rs_i == '0) begin
         // x0 is hardwired; producers writing x0 never forward
         value_o = '0;
      end else if (ex_hit && ex_fwd_is_load_i) begin
         pending_o = 1'b1;
      end else if (ex_hit) begin
         value_o = ex_fwd_data_i;
      end else if (wb_hit) begin
         value_o = wb_fwd_data_i;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX operand stage with forwarding and load-use wait
//
// Purpose: captures a decoded instruction, resolves both ALU operands through
//          forwarding, waits for pending load data, then presents the ALU
//          operands with a valid/ready handshake.
// Ports: clk, rst_n (async active-low); bus - id_ex_stage_if slave modport
//        carrying the decode offer, flush, forwarding sources and ALU outputs.
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int REGW = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   id_ex_stage_if.slave bus
);

   stage_state_e    state_q, state_d;
   logic [XLEN-1:0] a_q, a_d, b_q, b_d;
   logic            a_pend_q, a_pend_d, b_pend_q, b_pend_d;
   alu_sel_t        sel_q, sel_d;
   logic [REGW-1:0] rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;

   logic            waiting, in_ready, capture;
   logic [REGW-1:0] res_a_rs, res_b_rs;
   logic [XLEN-1:0] res_a_rf, res_b_rf, res_a_val, res_b_val, b_cap_val;
   logic            res_a_pend, res_b_pend, b_cap_pend;

   assign waiting  = (state_q == ST_WAIT);
   assign in_ready = (state_q == ST_EMPTY) || ((state_q == ST_FULL) && bus.out_ready);
   assign capture  = bus.in_valid && in_ready && !bus.flush;

   // In WAIT the resolvers re-examine the held instruction; a pending operand
   // keeps its captured register-file data in a_q/b_q as the fallback value.
   assign res_a_rs = waiting ? rs1_q : bus.in_rs1;
   assign res_a_rf = waiting ? a_q   : bus.in_rs1_data;
   assign res_b_rs = waiting ? rs2_q : bus.in_rs2;
   assign res_b_rf = waiting ? b_q   : bus.in_rs2_data;

   operand_resolve #(.XLEN(XLEN), .REGW(REGW)) u_res_a (
      .rs_i(res_a_rs), .rf_data_i(res_a_rf),
      .ex_fwd_valid_i(bus.ex_fwd_valid), .ex_fwd_is_load_i(bus.ex_fwd_is_load),
      .ex_fwd_rd_i(bus.ex_fwd_rd), .ex_fwd_data_i(bus.ex_fwd_data),
      .wb_fwd_valid_i(bus.wb_fwd_valid), .wb_fwd_rd_i(bus.wb_fwd_rd),
      .wb_fwd_data_i(bus.wb_fwd_data),
      .pending_o(res_a_pend), .value_o(res_a_val)
   );

   operand_resolve #(.XLEN(XLEN), .REGW(REGW)) u_res_b (
      .rs_i(res_b_rs), .rf_data_i(res_b_rf),
      .ex_fwd_valid_i(bus.ex_fwd_valid), .ex_fwd_is_load_i(bus.ex_fwd_is_load),
      .ex_fwd_rd_i(bus.ex_fwd_rd), .ex_fwd_data_i(bus.ex_fwd_data),
      .wb_fwd_valid_i(bus.wb_fwd_valid), .wb_fwd_rd_i(bus.wb_fwd_rd),
      .wb_fwd_data_i(bus.wb_fwd_data),
      .pending_o(res_b_pend), .value_o(res_b_val)
   );

   // An immediate operand B is never pending, whatever rs2 happens to hold.
   assign b_cap_val  = bus.in_use_imm ? bus.in_imm : res_b_val;
   assign b_cap_pend = !bus.in_use_imm && res_b_pend;

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      a_pend_d = a_pend_q;
      b_pend_d = b_pend_q;
      sel_d    = sel_q;
      rd_d     = rd_q;
      rs1_d    = rs1_q;
      rs2_d    = rs2_q;
      if (bus.flush) begin
         state_d  = ST_EMPTY;
         a_pend_d = 1'b0;
         b_pend_d = 1'b0;
      end else if (capture) begin
         a_d      = res_a_val;
         b_d      = b_cap_val;
         a_pend_d = res_a_pend;
         b_pend_d = b_cap_pend;
         sel_d    = bus.in_alu_sel;
         rd_d     = bus.in_rd;
         rs1_d    = bus.in_rs1;
         rs2_d    = bus.in_rs2;
         state_d  = (res_a_pend || b_cap_pend) ? ST_WAIT : ST_FULL;
      end else begin
         case (state_q)
            ST_WAIT: begin
               // Resolved operands stay frozen; only pending ones update.
               if (a_pend_q && !res_a_pend) begin
                  a_d      = res_a_val;
                  a_pend_d = 1'b0;
               end
               if (b_pend_q && !res_b_pend) begin
                  b_d      = res_b_val;
                  b_pend_d = 1'b0;
               end
               if ((!a_pend_q || !res_a_pend) && (!b_pend_q || !res_b_pend)) begin
                  state_d = ST_FULL;
               end
            end
            ST_FULL: begin
               if (bus.out_ready) begin
                  state_d = ST_EMPTY;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_EMPTY;
         a_q      <= '0;
         b_q      <= '0;
         a_pend_q <= 1'b0;
         b_pend_q <= 1'b0;
         sel_q    <= ALU_NOP;
         rd_q     <= '0;
         rs1_q    <= '0;
         rs2_q    <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         a_pend_q <= a_pend_d;
         b_pend_q <= b_pend_d;
         sel_q    <= sel_d;
         rd_q     <= rd_d;
         rs1_q    <= rs1_d;
         rs2_q    <= rs2_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = (state_q == ST_FULL);
   assign bus.alu_sel   = (state_q == ST_FULL) ? sel_q : ALU_NOP;
   assign bus.alu_a     = a_q;
   assign bus.alu_b     = b_q;
   assign bus.out_rd    = rd_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
module tb_id_ex_stage;
   import id_ex_stage_pkg::*;

   localparam int XLEN = 32;
   localparam int REGW = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   id_ex_stage_if #(.XLEN(XLEN), .REGW(REGW)) bus ();

   id_ex_stage #(.XLEN(XLEN), .REGW(REGW)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus.slave)
   );

   int tests = 0;
   int fails = 0;

   typedef struct {
      string       name;
      alu_sel_t    sel;
      logic [4:0]  rs1;
      logic [31:0] d1;
      logic [4:0]  rs2;
      logic [31:0] d2;
      logic [31:0] imm;
      logic        use_imm;
      logic        exv;
      logic        exl;
      logic [4:0]  exrd;
      logic [31:0] exd;
      logic        wbv;
      logic [4:0]  wbrd;
      logic [31:0] wbd;
      logic [4:0]  rd;
      logic [31:0] ea;
      logic [31:0] eb;
   } vec_t;

   vec_t vecs[8];

   // reference model state: one held instruction, per-operand pending flags
   bit          m_has, m_pa, m_pb;
   logic [31:0] m_a, m_b;
   logic [3:0]  m_sel;
   logic [4:0]  m_rd, m_rs1, m_rs2;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic v, input alu_sel_t sel, input logic [4:0] rs1,
                            input logic [31:0] d1, input logic [4:0] rs2, input logic [31:0] d2,
                            input logic [31:0] imm, input logic use_imm, input logic [4:0] rd);
      bus.in_valid    = v;
      bus.in_alu_sel  = sel;
      bus.in_rs1      = rs1;
      bus.in_rs1_data = d1;
      bus.in_rs2      = rs2;
      bus.in_rs2_data = d2;
      bus.in_imm      = imm;
      bus.in_use_imm  = use_imm;
      bus.in_rd       = rd;
   endtask

   task automatic set_fwd(input logic exv, input logic exl, input logic [4:0] exrd,
                          input logic [31:0] exd, input logic wbv, input logic [4:0] wbrd,
                          input logic [31:0] wbd);
      bus.ex_fwd_valid   = exv;
      bus.ex_fwd_is_load = exl;
      bus.ex_fwd_rd      = exrd;
      bus.ex_fwd_data    = exd;
      bus.wb_fwd_valid   = wbv;
      bus.wb_fwd_rd      = wbrd;
      bus.wb_fwd_data    = wbd;
   endtask

   task automatic idle();
      set_instr(1'b0, ALU_NOP, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0);
      set_fwd(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;
   endtask

   // Forwarding rule written straight from the priority list.
   function automatic void ref_resolve(input logic [4:0] rs, input logic [31:0] rf,
                                       output bit pend, output logic [31:0] val);
      pend = 1'b0;
      val  = rf;
      if (rs == 5'd0) val = 32'd0;
      else if (bus.ex_fwd_valid && bus.ex_fwd_rd == rs) begin
         if (bus.ex_fwd_is_load) pend = 1'b1;
         else val = bus.ex_fwd_data;
      end else if (bus.wb_fwd_valid && bus.wb_fwd_rd == rs) val = bus.wb_fwd_data;
   endfunction

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
      chk({tag, "_alu_sel"}, {28'd0, bus.alu_sel}, {28'd0, ALU_NOP});
      chk({tag, "_alu_a"}, bus.alu_a, 32'd0);
      chk({tag, "_alu_b"}, bus.alu_b, 32'd0);
      chk({tag, "_out_rd"}, {27'd0, bus.out_rd}, 32'd0);
   endtask

   initial begin
      bit          ov, exp_ready, pa, pb;
      logic [31:0] va, vb;

      idle();
      #2;
      check_reset_outputs("reset");
      chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
      tick();
      tick();
      #2 rst_n = 1'b1;
      tick();

      // ---------------- table-driven single-instruction vectors
      vecs[0] = '{"add_basic", ALU_ADD, 5'd3, 32'd5, 5'd4, 32'd7, 32'd0, 1'b0,
                  1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd1, 32'd5, 32'd7};
      vecs[1] = '{"ex_over_wb", ALU_ADD, 5'd3, 32'd1, 5'd4, 32'd2, 32'd0, 1'b0,
                  1'b1, 1'b0, 5'd3, 32'h10, 1'b1, 5'd3, 32'h20, 5'd2, 32'h10, 32'd2};
      vecs[2] = '{"x0_ignores_ex", ALU_SUB, 5'd0, 32'h55, 5'd4, 32'd9, 32'd0, 1'b0,
                  1'b1, 1'b0, 5'd0, 32'h99, 1'b0, 5'd0, 32'd0, 5'd3, 32'd0, 32'd9};
      vecs[3] = '{"wb_only", ALU_OR, 5'd5, 32'd1, 5'd7, 32'd2, 32'd0, 1'b0,
                  1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hCAFE, 5'd4, 32'd1, 32'hCAFE};
      vecs[4] = '{"imm_over_load", ALU_AND, 5'd2, 32'hFFFF_FFFF, 5'd9, 32'd3, 32'h8000_0000, 1'b1,
                  1'b1, 1'b1, 5'd9, 32'd1, 1'b0, 5'd0, 32'd0, 5'd5, 32'hFFFF_FFFF, 32'h8000_0000};
      vecs[5] = '{"invalid_sel", ALU_INVALID, 5'd1, 32'h1234_5678, 5'd2, 32'h9ABC_DEF0, 32'd0, 1'b0,
                  1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd31, 32'h1234_5678, 32'h9ABC_DEF0};
      vecs[6] = '{"unknown_sel_wb_x0", 4'hD, 5'd0, 32'hAAAA, 5'd1, 32'd5, 32'd0, 1'b0,
                  1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h77, 5'd6, 32'd0, 32'd5};
      vecs[7] = '{"ex_both", ALU_XOR, 5'd8, 32'd1, 5'd8, 32'd2, 32'd0, 1'b0,
                  1'b1, 1'b0, 5'd8, 32'hFEED_BEEF, 1'b0, 5'd0, 32'd0, 5'd7, 32'hFEED_BEEF, 32'hFEED_BEEF};

      for (int i = 0; i < 8; i++) begin
         idle();
         bus.out_ready = 1'b1;
         tick();
         set_instr(1'b1, vecs[i].sel, vecs[i].rs1, vecs[i].d1, vecs[i].rs2, vecs[i].d2,
                   vecs[i].imm, vecs[i].use_imm, vecs[i].rd);
         set_fwd(vecs[i].exv, vecs[i].exl, vecs[i].exrd, vecs[i].exd,
                 vecs[i].wbv, vecs[i].wbrd, vecs[i].wbd);
         bus.out_ready = 1'b0;
         #1;
         chk({vecs[i].name, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
         tick();
         idle();
         #1;
         chk({vecs[i].name, "_out_valid"}, {31'd0, bus.out_valid}, 32'd1);
         chk({vecs[i].name, "_alu_a"}, bus.alu_a, vecs[i].ea);
         chk({vecs[i].name, "_alu_b"}, bus.alu_b, vecs[i].eb);
         chk({vecs[i].name, "_alu_sel"}, {28'd0, bus.alu_sel}, {28'd0, vecs[i].sel});
         chk({vecs[i].name, "_out_rd"}, {27'd0, bus.out_rd}, {27'd0, vecs[i].rd});
      end

      // ---------------- back-pressure then back-to-back replacement
      idle();
      bus.out_ready = 1'b1;
      tick();
      idle();
      set_instr(1'b1, ALU_ADD, 5'd1, 32'h11, 5'd2, 32'h22, 32'd0, 1'b0, 5'd3);
      tick();
      idle();
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
         chk("stall_alu_a", bus.alu_a, 32'h11);
         chk("stall_alu_b", bus.alu_b, 32'h22);
         chk("stall_alu_sel", {28'd0, bus.alu_sel}, {28'd0, ALU_ADD});
         chk("stall_out_rd", {27'd0, bus.out_rd}, 32'd3);
         chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
         tick();
      end
      set_instr(1'b1, ALU_SUB, 5'd4, 32'h44, 5'd5, 32'h55, 32'd0, 1'b0, 5'd6);
      bus.out_ready = 1'b1;
      #1;
      chk("b2b_in_ready", {31'd0, bus.in_ready}, 32'd1);
      tick();
      idle();
      #1;
      chk("b2b_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("b2b_alu_a", bus.alu_a, 32'h44);
      chk("b2b_alu_b", bus.alu_b, 32'h55);
      chk("b2b_alu_sel", {28'd0, bus.alu_sel}, {28'd0, ALU_SUB});
      chk("b2b_out_rd", {27'd0, bus.out_rd}, 32'd6);

      // ---------------- flush in FULL beats the offered instruction
      set_instr(1'b1, ALU_OR, 5'd7, 32'h77, 5'd8, 32'h88, 32'd0, 1'b0, 5'd9);
      bus.flush     = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      idle();
      #1;
      chk("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("flush_alu_sel", {28'd0, bus.alu_sel}, {28'd0, ALU_NOP});
      chk("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
      tick();
      chk("flush_no_capture", {31'd0, bus.out_valid}, 32'd0);

      // ---------------- load-use wait on operand B
      set_instr(1'b1, ALU_ADD, 5'd1, 32'd1, 5'd6, 32'h66, 32'd0, 1'b0, 5'd2);
      set_fwd(1'b1, 1'b1, 5'd6, 32'd0, 1'b0, 5'd0, 32'd0);
      tick();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      chk("wait1_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("wait1_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("wait1_alu_sel", {28'd0, bus.alu_sel}, {28'd0, ALU_NOP});
      tick();
      set_fwd(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'hDEAD);
      #1;
      chk("wait2_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("wait2_in_ready", {31'd0, bus.in_ready}, 32'd0);
      tick();
      idle();
      #1;
      chk("wait_done_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("wait_done_alu_b", bus.alu_b, 32'hDEAD);
      chk("wait_done_alu_a", bus.alu_a, 32'd1);

      // ---------------- asynchronous reset in WAIT
      bus.out_ready = 1'b1;
      tick();
      set_instr(1'b1, ALU_XOR, 5'd7, 32'h70, 5'd0, 32'd0, 32'd0, 1'b0, 5'd9);
      set_fwd(1'b1, 1'b1, 5'd7, 32'd0, 1'b0, 5'd0, 32'd0);
      tick();
      bus.in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs("arst");
      @(negedge clk);
      rst_n = 1'b1;
      set_fwd(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234);
      tick();
      chk("arst_hold0_out_valid", {31'd0, bus.out_valid}, 32'd0);
      tick();
      chk("arst_hold1_out_valid", {31'd0, bus.out_valid}, 32'd0);
      idle();
      set_instr(1'b1, ALU_ADD, 5'd3, 32'd5, 5'd4, 32'd7, 32'd0, 1'b0, 5'd1);
      tick();
      idle();
      #1;
      chk("arst_recapture_out_valid", {31'd0, bus.out_valid}, 32'd1);

      // ---------------- randomized run against the reference model
      rst_n = 1'b0;
      #3 rst_n = 1'b1;
      m_has = 1'b0;
      m_pa  = 1'b0;
      m_pb  = 1'b0;
      m_a = '0; m_b = '0; m_sel = '0; m_rd = '0; m_rs1 = '0; m_rs2 = '0;
      tick();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         set_instr($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                   5'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 3)), $urandom,
                   $urandom, $urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)));
         set_fwd($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, 5'($urandom_range(0, 3)),
                 $urandom, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), $urandom);
         bus.flush     = ($urandom_range(0, 19) == 0);
         bus.out_ready = ($urandom_range(0, 2) != 0);
         #3;
         ov        = m_has && !m_pa && !m_pb;
         exp_ready = !m_has || (ov && bus.out_ready);
         chk("rnd_out_valid", {31'd0, bus.out_valid}, {31'd0, ov});
         chk("rnd_in_ready", {31'd0, bus.in_ready}, {31'd0, exp_ready});
         chk("rnd_alu_sel", {28'd0, bus.alu_sel}, {28'd0, ov ? m_sel : ALU_NOP});
         if (ov) begin
            chk("rnd_alu_a", bus.alu_a, m_a);
            chk("rnd_alu_b", bus.alu_b, m_b);
            chk("rnd_out_rd", {27'd0, bus.out_rd}, {27'd0, m_rd});
         end
         if (bus.flush) begin
            m_has = 1'b0;
         end else if (bus.in_valid && exp_ready) begin
            ref_resolve(bus.in_rs1, bus.in_rs1_data, pa, va);
            if (bus.in_use_imm) begin
               pb = 1'b0;
               vb = bus.in_imm;
            end else begin
               ref_resolve(bus.in_rs2, bus.in_rs2_data, pb, vb);
            end
            m_has = 1'b1; m_pa = pa; m_pb = pb; m_a = va; m_b = vb;
            m_sel = bus.in_alu_sel; m_rd = bus.in_rd; m_rs1 = bus.in_rs1; m_rs2 = bus.in_rs2;
         end else if (m_has && (m_pa || m_pb)) begin
            if (m_pa) begin
               ref_resolve(m_rs1, m_a, pa, va);
               if (!pa) begin m_pa = 1'b0; m_a = va; end
            end
            if (m_pb) begin
               ref_resolve(m_rs2, m_b, pb, vb);
               if (!pb) begin m_pb = 1'b0; m_b = vb; end
            end
         end else if (ov && bus.out_ready) begin
            m_has = 1'b0;
         end
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
